// File: rtl/spi_master_ctrl.sv
// SPI master: sends a 10-bit command frame MSB first and, for read-data commands, collects an 8-bit reply.
// Optional start_err output is enabled by defining SPI_MASTER_START_ERR_EN.
module spi_master_ctrl #(
    parameter int RD_LAT = 2,
    parameter int GAP    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [9:0] cmd,
    output logic       busy,
    output logic       done,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO
`ifdef SPI_MASTER_START_ERR_EN
    ,
    output logic       start_err
`endif
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_MODE  = 3'd2;
    localparam logic [2:0] S_SHIFT = 3'd3;
    localparam logic [2:0] S_TURN  = 3'd4;
    localparam logic [2:0] S_RECV  = 3'd5;
    localparam logic [2:0] S_END   = 3'd6;
    localparam logic [2:0] S_HOLD  = 3'd7;

    logic [2:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [9:0] cmd_q, cmd_d;
    logic [7:0] shift_q, shift_d;
    logic       ss_n_q, ss_n_d;
    logic       mosi_q, mosi_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [7:0] rd_data_q, rd_data_d;
    logic       rd_valid_q, rd_valid_d;
    logic       start_err_q, start_err_d;
    logic       is_rd_data;

    assign is_rd_data = (cmd_q[9:8] == 2'b11);

    // Host handshake: start is taken only while busy is low (IDLE); cmd is captured on that edge and
    // start is dropped whenever busy is high.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cmd_d   = cmd_q;
        shift_d = shift_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cmd_d   = cmd;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: state_d = S_MODE;
            S_MODE: begin
                cnt_d   = 4'd0;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                if (cnt_q == 4'd9) begin
                    cnt_d   = 4'd0;
                    state_d = is_rd_data ? S_TURN : S_END;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_TURN: begin
                if (cnt_q == 4'(RD_LAT - 1)) begin
                    cnt_d   = 4'd0;
                    state_d = S_RECV;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_RECV: begin
                shift_d = {shift_q[6:0], MISO};
                if (cnt_q == 4'd7) begin
                    cnt_d   = 4'd0;
                    state_d = S_END;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_END: begin
                cnt_d   = 4'd0;
                state_d = (GAP > 1) ? S_HOLD : S_IDLE;
            end
            default: begin
                if (cnt_q == 4'(GAP - 2)) begin
                    cnt_d   = 4'd0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
        endcase
    end

    // Pin outputs are registered from the current state, so they trail the state by one cycle.
    always_comb begin
        ss_n_d      = 1'b1;
        mosi_d      = 1'b0;
        done_d      = 1'b0;
        rd_valid_d  = 1'b0;
        rd_data_d   = rd_data_q;
        busy_d      = (state_d != S_IDLE);
        start_err_d = start && (state_q != S_IDLE);
        case (state_q)
            S_SETUP: ss_n_d = 1'b0;
            S_MODE: begin
                ss_n_d = 1'b0;
                mosi_d = cmd_q[9];
            end
            S_SHIFT: begin
                ss_n_d = 1'b0;
                mosi_d = cmd_q[4'd9 - cnt_q];
            end
            S_TURN:  ss_n_d = 1'b0;
            S_RECV:  ss_n_d = 1'b0;
            S_END: begin
                done_d = 1'b1;
                if (is_rd_data) begin
                    rd_valid_d = 1'b1;
                    rd_data_d  = shift_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            cmd_q       <= 10'd0;
            shift_q     <= 8'd0;
            ss_n_q      <= 1'b1;
            mosi_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_data_q   <= 8'h00;
            rd_valid_q  <= 1'b0;
            start_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_q       <= cmd_d;
            shift_q     <= shift_d;
            ss_n_q      <= ss_n_d;
            mosi_q      <= mosi_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            start_err_q <= start_err_d;
        end
    end

    assign SS_n     = ss_n_q;
    assign MOSI     = mosi_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
`ifdef SPI_MASTER_START_ERR_EN
    assign start_err = start_err_q;
`else
    logic unused_start_err;
    assign unused_start_err = start_err_q;
`endif

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl: write, read-addr, read-data, mid-frame reset, start while busy, back-to-back.
module tb_spi_master_ctrl;
  localparam int RD_LAT = 2;
  localparam int GAP    = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [9:0] cmd;
  logic       busy;
  logic       done;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;
`ifdef SPI_MASTER_START_ERR_EN
  logic       start_err;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] rd_exp = 8'h00;

  spi_master_ctrl #(.RD_LAT(RD_LAT), .GAP(GAP)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .cmd      (cmd),
    .busy     (busy),
    .done     (done),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO)
`ifdef SPI_MASTER_START_ERR_EN
    ,
    .start_err(start_err)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s c=%0d got=%0h expected=%0h", tag, c, obs, exp);
    end
  endtask

  // Caller sets start=1 and cmd before calling; c counts edges after the accepting edge N.
  task automatic run_frame(input logic [9:0] fcmd, input logic [7:0] miso_byte, input bit hold,
                           input int poke, input bit chain, input logic [9:0] next_cmd);
    bit   is_rd;
    int   e;
    int   last;
    int   low;
    logic exp_mosi;
    is_rd = (fcmd[9:8] == 2'b11);
    e     = is_rd ? 13 + RD_LAT + 8 : 13;
    last  = chain ? e : e + 1;
    low   = 0;
    for (int c = 0; c <= last; c++) begin
      @(negedge clk);
      if (!SS_n) low++;
      if (c == 2) exp_mosi = fcmd[9];
      else if (c >= 3 && c <= 12) exp_mosi = fcmd[12 - c];
      else exp_mosi = 1'b0;
      chk("ss_n", c, SS_n, (c >= 1 && c <= e - 1) ? 0 : 1);
      chk("mosi", c, MOSI, exp_mosi);
      chk("busy", c, busy, (c <= e - 1) ? 1 : 0);
      chk("done", c, done, (c == e) ? 1 : 0);
      chk("rd_valid", c, rd_valid, (is_rd && c == e) ? 1 : 0);
      if (is_rd && c == e) rd_exp = miso_byte;
      chk("rd_data", c, rd_data, rd_exp);
`ifdef SPI_MASTER_START_ERR_EN
      chk("start_err", c, start_err, hold ? ((c >= 1 && c <= e) ? 1 : 0) : ((poke >= 0 && c == poke + 1) ? 1 : 0));
`endif
      start = hold ? 1'b1 : (c == poke);
      cmd   = (chain && c == last) ? next_cmd : 10'($urandom);
      if (c >= 12 + RD_LAT && c <= 12 + RD_LAT + 7) MISO = miso_byte[7 - (c - 12 - RD_LAT)];
      else MISO = 1'b1;
    end
    chk("ss_low_cycles", 0, low, e - 1);
  endtask

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    cmd   = 10'd0;
    MISO  = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ss_n", 0, SS_n, 1);
    chk("rst_mosi", 0, MOSI, 0);
    chk("rst_busy", 0, busy, 0);
    chk("rst_done", 0, done, 0);
    chk("rst_rd_valid", 0, rd_valid, 0);
    chk("rst_rd_data", 0, rd_data, 8'h00);
`ifdef SPI_MASTER_START_ERR_EN
    chk("rst_start_err", 0, start_err, 0);
`endif
    rst = 1'b1;
    @(negedge clk);

    // write-address frame
    cmd = 10'b0010101011; start = 1'b1;
    run_frame(10'b0010101011, 8'h00, 1'b0, -1, 1'b0, 10'd0);

    // read-address frame with a stray start pulse mid-frame
    cmd = 10'b1010101101; start = 1'b1;
    run_frame(10'b1010101101, 8'h00, 1'b0, 5, 1'b0, 10'd0);

    // read-data frame, slave returns A5
    cmd = 10'b1100000000; start = 1'b1;
    run_frame(10'b1100000000, 8'hA5, 1'b0, -1, 1'b0, 10'd0);

    // reset during SHIFT bit 4 of a write-data frame
    cmd = 10'b0101001110; start = 1'b1;
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      start = 1'b0;
      cmd   = 10'($urandom);
    end
    chk("mid_mosi", 6, MOSI, 1);
    chk("mid_ss_n", 6, SS_n, 0);
    rst = 1'b0;
    @(negedge clk);
    rd_exp = 8'h00;
    chk("rstmid_ss_n", 7, SS_n, 1);
    chk("rstmid_busy", 7, busy, 0);
    chk("rstmid_mosi", 7, MOSI, 0);
    chk("rstmid_done", 7, done, 0);
    chk("rstmid_rd_data", 7, rd_data, rd_exp);
    rst = 1'b1;
    for (int c = 8; c < 20; c++) begin
      @(negedge clk);
      chk("post_rst_done", c, done, 0);
      chk("post_rst_ss_n", c, SS_n, 1);
    end

    // write frame after the aborted one
    cmd = 10'b0111110000; start = 1'b1;
    run_frame(10'b0111110000, 8'h00, 1'b0, -1, 1'b0, 10'd0);

    // read-data with start held high throughout, chained straight into a write
    cmd = 10'b1111111111; start = 1'b1;
    run_frame(10'b1111111111, 8'h3C, 1'b1, -1, 1'b1, 10'b0001011010);
    run_frame(10'b0001011010, 8'h00, 1'b0, -1, 1'b0, 10'd0);

    repeat (3) @(negedge clk);
    chk("final_rd_data", 0, rd_data, 8'h3C);
    chk("final_ss_n", 0, SS_n, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
